gaussian_filter_pipe: RTL and testbench

//  Parametrised KxK Gaussian smoothing stage for the canny_edge pixel path, placed between the

---
 rtl/gaussian_filter_pipe_pkg.sv | 32 +++
 rtl/gauss_coef_bank.sv | 64 ++++++
 rtl/gaussian_filter_pipe.sv | 144 ++++++++++++++
 tb/tb_gaussian_filter_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_filter_pipe_pkg.sv
// Shared constants for the Gaussian smoothing stage: default binomial kernels,
// their post-scale shifts, and the accumulator width helper.
package gaussian_filter_pipe_pkg;

    localparam int unsigned GAUSS_K3 [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    localparam int unsigned GAUSS_K3_SHIFT = 4;

    localparam int unsigned GAUSS_K5 [25] = '{ 1,  4,  6,  4,  1,
                                               4, 16, 24, 16,  4,
                                               6, 24, 36, 24,  6,
                                               4, 16, 24, 16,  4,
                                               1,  4,  6,  4,  1};
    localparam int unsigned GAUSS_K5_SHIFT = 8;

    function automatic int unsigned gauss_default_coef(input int unsigned k, input int unsigned i);
        if (k == 5) begin
            return (i < 25) ? GAUSS_K5[i[4:0]] : 0;
        end
        return (i < 9) ? GAUSS_K3[i[3:0]] : 0;
    endfunction

    function automatic int unsigned gauss_default_shift(input int unsigned k);
        return (k == 5) ? GAUSS_K5_SHIFT : GAUSS_K3_SHIFT;
    endfunction

    // Full-precision sum of K*K unsigned products.
    function automatic int unsigned gauss_sum_w(input int unsigned data_w, input int unsigned coef_w,
                                                input int unsigned k);
        return data_w + coef_w + $clog2(k * k);
    endfunction

endpackage

// File: rtl/gauss_coef_bank.sv
// Shadow/active coefficient and shift register file. Writes land in the shadow set;
// a commit copies the pre-write shadow into the active set used by the pipeline.
module gauss_coef_bank
    import gaussian_filter_pipe_pkg::*;
#(
    parameter int unsigned K      = 3,
    parameter int unsigned COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(K*K)-1:0]   cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_commit,
    output logic [K*K*COEF_W-1:0]    coef_act,
    output logic [4:0]               shift_act
);

    localparam int unsigned N  = K * K;
    localparam int unsigned AW = $clog2(K * K);

    logic [COEF_W-1:0] shadow_q [N];
    logic [COEF_W-1:0] active_q [N];
    logic [4:0]        shift_sh_q;
    logic [4:0]        shift_act_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= COEF_W'(gauss_default_coef(K, unsigned'(i)));
                active_q[i] <= COEF_W'(gauss_default_coef(K, unsigned'(i)));
            end
            shift_sh_q  <= 5'(gauss_default_shift(K));
            shift_act_q <= 5'(gauss_default_shift(K));
        end else begin
            // Non-blocking reads of shadow_q make a same-cycle write invisible to the commit.
            if (cfg_commit) begin
                for (int i = 0; i < N; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                shift_act_q <= shift_sh_q;
            end
            for (int i = 0; i < N; i++) begin
                if (cfg_we && cfg_addr == AW'(i)) begin
                    shadow_q[i] <= cfg_data;
                end
            end
            if (cfg_we && cfg_addr == AW'(N - 1)) begin
                shift_sh_q <= cfg_shift;
            end
        end
    end

    always_comb begin
        coef_act = '0;
        for (int i = 0; i < N; i++) begin
            coef_act[i*COEF_W +: COEF_W] = active_q[i];
        end
    end

    assign shift_act = shift_act_q;

endmodule

// File: rtl/gaussian_filter_pipe.sv
// KxK Gaussian smoothing stage: multiply, sum, round/shift/saturate in three
// stages under one global enable, with programmable coefficients and bypass.
module gaussian_filter_pipe
    import gaussian_filter_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ROUND  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [K*K*DATA_W-1:0]    win_in,
    input  logic                     win_valid,
    output logic                     win_ready,
    output logic [DATA_W-1:0]        pix_out,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    input  logic                     bypass,
    input  logic                     cfg_we,
    input  logic [$clog2(K*K)-1:0]   cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_commit
);

    localparam int unsigned N      = K * K;
    localparam int unsigned CENTRE = N / 2;
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned SUM_W  = gauss_sum_w(DATA_W, COEF_W, K);
    // Headroom for a rounding term of up to 2^30.
    localparam int unsigned R_W    = SUM_W + 32;
    localparam logic [DATA_W-1:0] PIX_MAX = '1;

    generate
        if (K != 3 && K != 5) begin : g_bad_k
            $error("gaussian_filter_pipe: K must be 3 or 5");
        end
    endgenerate

    logic [N*COEF_W-1:0] coef_act;
    logic [4:0]          shift_act;

    gauss_coef_bank #(
        .K      (K),
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_shift  (cfg_shift),
        .cfg_commit (cfg_commit),
        .coef_act   (coef_act),
        .shift_act  (shift_act)
    );

    logic en;
    assign en        = !pix_valid || pix_ready;
    assign win_ready = en;

    // S1: per-tap products; the shift travels with the beat so commits never touch it.
    logic              v1_q, byp1_q;
    logic [DATA_W-1:0] ctr1_q;
    logic [4:0]        shift1_q;
    logic [PROD_W-1:0] prod_q [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            byp1_q   <= 1'b0;
            ctr1_q   <= '0;
            shift1_q <= '0;
            for (int i = 0; i < N; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            v1_q     <= win_valid;
            byp1_q   <= bypass;
            ctr1_q   <= win_in[CENTRE*DATA_W +: DATA_W];
            shift1_q <= shift_act;
            for (int i = 0; i < N; i++) begin
                prod_q[i] <= PROD_W'(coef_act[i*COEF_W +: COEF_W]) *
                             PROD_W'(win_in[i*DATA_W +: DATA_W]);
            end
        end
    end

    // S2: full-precision sum.
    logic [SUM_W-1:0]  sum_d, sum2_q;
    logic              v2_q, byp2_q;
    logic [DATA_W-1:0] ctr2_q;
    logic [4:0]        shift2_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q     <= 1'b0;
            byp2_q   <= 1'b0;
            ctr2_q   <= '0;
            shift2_q <= '0;
            sum2_q   <= '0;
        end else if (en) begin
            v2_q     <= v1_q;
            byp2_q   <= byp1_q;
            ctr2_q   <= ctr1_q;
            shift2_q <= shift1_q;
            sum2_q   <= sum_d;
        end
    end

    // S3: round, scale, saturate or bypass.
    logic [R_W-1:0]    rnd, r_sum, y;
    logic [DATA_W-1:0] pix_d, pix_q;
    logic              v3_q;

    always_comb begin
        rnd   = (ROUND != 0 && shift2_q != 5'd0) ? (R_W'(1) << (shift2_q - 5'd1)) : '0;
        r_sum = R_W'(sum2_q) + rnd;
        y     = r_sum >> shift2_q;
        pix_d = byp2_q ? ctr2_q : ((y > R_W'(PIX_MAX)) ? PIX_MAX : y[DATA_W-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q  <= 1'b0;
            pix_q <= '0;
        end else if (en) begin
            v3_q  <= v2_q;
            pix_q <= pix_d;
        end
    end

    assign pix_out   = pix_q;
    assign pix_valid = v3_q;

endmodule

// File: tb/tb_gaussian_filter_pipe.sv
// Scoreboard bench for gaussian_filter_pipe (K=3, 8-bit): driver pushes model results at
// acceptance, an independent monitor pops and compares on every output handshake.
module tb_gaussian_filter_pipe;

    localparam int DW       = 8;
    localparam int KK       = 3;
    localparam int N        = KK * KK;
    localparam int TB_ROUND = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] win_in;
    logic            win_valid, win_ready;
    logic [DW-1:0]   pix_out;
    logic            pix_valid, pix_ready;
    logic            bypass;
    logic            cfg_we, cfg_commit;
    logic [3:0]      cfg_addr;
    logic [7:0]      cfg_data;
    logic [4:0]      cfg_shift;

    gaussian_filter_pipe #(
        .DATA_W (DW),
        .K      (KK),
        .COEF_W (8),
        .ROUND  (TB_ROUND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .win_in     (win_in),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .bypass     (bypass),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_shift  (cfg_shift),
        .cfg_commit (cfg_commit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [$];
    bit rdy_rand = 1'b0;

    // Reference coefficient state.
    int m_sh [N];
    int m_act [N];
    int m_shift_sh, m_shift_act;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        int k3 [N];
        k3 = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = k3[i];
            m_act[i] = k3[i];
        end
        m_shift_sh  = 4;
        m_shift_act = 4;
    endtask

    function automatic int model_out(input logic [N*DW-1:0] w, input bit byp);
        longint sum = 0;
        longint y;
        if (byp) return int'(w[(N/2)*DW +: DW]);
        for (int i = 0; i < N; i++) sum += longint'(m_act[i]) * longint'(w[i*DW +: DW]);
        if (TB_ROUND != 0 && m_shift_act != 0) sum += longint'(1) << (m_shift_act - 1);
        y = sum >> m_shift_act;
        return (y > 255) ? 255 : int'(y);
    endfunction

    function automatic logic [N*DW-1:0] uni(input int v);
        logic [N*DW-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = v[7:0];
        return w;
    endfunction

    // One clock cycle of stimulus; model state updates at the edge like the hardware.
    task automatic step(input bit v, input logic [N*DW-1:0] w, input bit byp, input bit we,
                        input int addr, input int data, input int sh, input bit commit,
                        output bit acc);
        win_valid  = v;
        win_in     = w;
        bypass     = byp;
        cfg_we     = we;
        cfg_addr   = addr[3:0];
        cfg_data   = data[7:0];
        cfg_shift  = sh[4:0];
        cfg_commit = commit;
        pix_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc = v && win_ready;
        if (acc) exp_q.push_back(model_out(w, byp));
        @(posedge clk);
        if (commit) begin
            for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            m_shift_act = m_shift_sh;
        end
        if (we && addr < N) begin
            m_sh[addr] = data;
            if (addr == N - 1) m_shift_sh = sh;
        end
        #1;
        win_valid  = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int c = 0; c < n; c++) step(0, '0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic send_beat(input logic [N*DW-1:0] w, input bit byp);
        bit acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) step(1, w, byp, 0, 0, 0, 0, 0, acc);
        if (!acc) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic cfg_write(input int addr, input int data, input int sh);
        bit acc;
        step(0, '0, 0, 1, addr, data, sh, 0, acc);
    endtask

    task automatic do_commit();
        bit acc;
        step(0, '0, 0, 0, 0, 0, 0, 1, acc);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle(1);
        idle(4);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pop on each handshake plus hold check while stalled.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_pix;
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", pix_valid, 1);
                    check("stall_data_hold", pix_out, prev_pix);
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check("output_without_expected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_out", pix_out, e);
                    end
                end
                prev_stall = pix_valid && !pix_ready;
                prev_pix   = pix_out;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        logic [N*DW-1:0] w;

        rst = 1'b1; win_in = '0; win_valid = 0; bypass = 0; pix_ready = 1;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_shift = 0; cfg_commit = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pix_valid", pix_valid, 0);
        check("reset_pix_out", pix_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_win_ready", win_ready, 1);
        @(posedge clk);
        #1;

        // Uniform 100 window through default kernel; valid on the third cycle after presentation.
        send_beat(uni(100), 0);
        @(negedge clk); check("lat_cycle1_valid", pix_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); check("lat_cycle2_valid", pix_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); check("lat_cycle3_valid", pix_valid, 1);
        check("lat_cycle3_data", pix_out, 100);
        @(posedge clk); #1;
        drain();

        // Impulse: 255*4/16 rounds to 64.
        w = '0; w[(N/2)*DW +: DW] = 8'hFF;
        send_beat(w, 0);
        drain();

        // Back-to-back 0..9 with random backpressure.
        rdy_rand = 1'b1;
        for (int v = 0; v < 10; v++) send_beat(uni(v), 0);
        drain();

        // Random coefficients and windows.
        for (int i = 0; i < N; i++) cfg_write(i, $urandom_range(0, 40), $urandom_range(0, 7));
        do_commit();
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < N; i++) w[i*DW +: DW] = 8'($urandom);
            send_beat(w, 1'($urandom_range(0, 3) == 0));
        end
        drain();
        rdy_rand = 1'b0;

        // Saturation with all coefs 255 and no shift.
        for (int i = 0; i < N; i++) cfg_write(i, 255, 0);
        do_commit();
        send_beat(uni(255), 0);
        drain();

        // Commit coinciding with beat B: B still uses the old set.
        for (int i = 0; i < N; i++) cfg_write(i, 1, 4);
        do_commit();
        for (int i = 0; i < N; i++) cfg_write(i, 0, 4);
        cfg_write(12, 77, 0);
        send_beat(uni(16), 0);
        step(1, uni(16), 0, 0, 0, 0, 0, 1, acc);
        check("commit_beat_b_accepted", acc, 1);
        send_beat(uni(16), 0);
        drain();
        // Same-cycle write and commit: the write must not reach the active set.
        step(0, '0, 0, 1, 0, 200, 4, 1, acc);
        send_beat(uni(16), 0);
        do_commit();
        send_beat(uni(16), 0);
        drain();

        // Bypass returns the centre pixel unfiltered.
        for (int i = 0; i < N; i++) w[i*DW +: DW] = 8'(i * 17 + 3);
        w[(N/2)*DW +: DW] = 8'h5A;
        send_beat(w, 1);
        drain();

        // Reset with three beats in flight.
        send_beat(uni(50), 0);
        send_beat(uni(60), 0);
        send_beat(uni(70), 0);
        check("inflight_before_reset", pix_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_pix_valid", pix_valid, 0);
        check("async_reset_pix_out", pix_out, 0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_win_ready", win_ready, 1);
        @(posedge clk); #1;
        idle(6);
        // Default kernel restored: impulse gives 64 again.
        w = '0; w[(N/2)*DW +: DW] = 8'hFF;
        send_beat(w, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
